// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module : traffic_pkg
//  Brief  : Lamp codes, fault codes, direction indices and monitor FSM states.
//  Rev    : 1.0  initial release
// ============================================================================
package traffic_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam logic [2:0] FLT_NONE        = 3'd0;
  localparam logic [2:0] FLT_ILLEGAL     = 3'd1;
  localparam logic [2:0] FLT_CONFLICT    = 3'd2;
  localparam logic [2:0] FLT_BAD_SEQ     = 3'd3;
  localparam logic [2:0] FLT_SHORT_GREEN = 3'd4;
  localparam logic [2:0] FLT_YELLOW_TIME = 3'd5;
  localparam logic [2:0] FLT_STARVE      = 3'd6;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_S = 2'd1;
  localparam logic [1:0] DIR_E = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_MON   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Lowest set index wins; an empty vector reports north.
  function automatic logic [1:0] low_dir(input logic [3:0] v);
    logic [1:0] d;
    d = DIR_N;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) d = 2'(i);
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_light_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module : traffic_light_monitor_if
//  Brief  : Lamp bus seen by the safety monitor plus its fault reporting.
//  Rev    : 1.0  initial release
// ============================================================================
interface traffic_light_monitor_if;
  logic [2:0] north;
  logic [2:0] south;
  logic [2:0] east;
  logic [2:0] west;
  logic       clear_fault;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] fault_dir;
  logic       force_red;

  modport master (
    output north, south, east, west, clear_fault,
    input  fault, fault_code, fault_dir, force_red
  );

  modport slave (
    input  north, south, east, west, clear_fault,
    output fault, fault_code, fault_dir, force_red
  );
endinterface
`default_nettype wire

// File: rtl/tl_dir_tracker.sv
`default_nettype none
// ============================================================================
//  Module : tl_dir_tracker
//  Brief  : Per-direction lamp history, saturating dwell counter and checks.
//  Rev    : 1.0  initial release
// ============================================================================
module tl_dir_tracker
  import traffic_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int MIN_GREEN  = 30,
  parameter int MIN_YELLOW = 5,
  parameter int MAX_YELLOW = 20,
  parameter int MAX_RED    = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic [2:0] i_lamp,
  output logic       o_illegal,
  output logic       o_bad_seq,
  output logic       o_short_green,
  output logic       o_yellow_time,
  output logic       o_starve,
  output logic       o_non_red
);

  localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_MIN_GREEN  = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] C_MIN_YELLOW = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] C_MAX_YELLOW = CNT_W'(MAX_YELLOW);
  localparam logic [CNT_W-1:0] C_MAX_RED    = CNT_W'(MAX_RED);

  logic [2:0]       r_lamp_q;
  logic [2:0]       r_lamp_p;
  logic [CNT_W-1:0] r_cnt;
  logic             w_change;
  logic             w_legal_step;

  assign w_change = (r_lamp_q != r_lamp_p);

  // r_cnt always holds the dwell of the phase in r_lamp_p, so on a change it
  // is the length of the phase being left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lamp_q <= LAMP_RED;
      r_lamp_p <= LAMP_RED;
      r_cnt    <= '0;
    end else begin
      r_lamp_q <= i_lamp;
      r_lamp_p <= r_lamp_q;
      if (i_clr)                  r_cnt <= '0;
      else if (w_change)          r_cnt <= C_ONE;
      else if (r_cnt != C_CNT_MAX) r_cnt <= r_cnt + C_ONE;
    end
  end

  always_comb begin
    w_legal_step  = ((r_lamp_p == LAMP_RED) && (r_lamp_q == LAMP_GRN)) ||
                    ((r_lamp_p == LAMP_GRN) && (r_lamp_q == LAMP_YEL)) ||
                    ((r_lamp_p == LAMP_YEL) && (r_lamp_q == LAMP_RED));
    o_illegal     = !((r_lamp_q == LAMP_RED) || (r_lamp_q == LAMP_YEL) ||
                      (r_lamp_q == LAMP_GRN));
    o_bad_seq     = w_change && !w_legal_step;
    o_short_green = (r_lamp_p == LAMP_GRN) && (r_lamp_q == LAMP_YEL) &&
                    (r_cnt < C_MIN_GREEN);
    o_yellow_time = (r_lamp_p == LAMP_YEL) &&
                    (((r_lamp_q == LAMP_RED) && (r_cnt < C_MIN_YELLOW)) ||
                     (r_cnt == C_MAX_YELLOW));
    o_starve      = (r_lamp_p == LAMP_RED) && (r_cnt == C_MAX_RED);
    o_non_red     = (r_lamp_q == LAMP_YEL) || (r_lamp_q == LAMP_GRN);
  end

endmodule
`default_nettype wire

// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
//  Module : traffic_light_monitor
//  Brief  : Lamp-bus safety checker; latches first fault and forces all red.
//  Rev    : 1.0  initial release
// ============================================================================
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int MIN_GREEN  = 30,
  parameter int MIN_YELLOW = 5,
  parameter int MAX_YELLOW = 20,
  parameter int MAX_RED    = 200
) (
  input  logic                    clk,
  input  logic                    rst_n,
  traffic_light_monitor_if.slave  bus
);

  if ((MAX_RED >= (1 << CNT_W)) || (MAX_YELLOW >= (1 << CNT_W)) ||
      (MIN_GREEN >= (1 << CNT_W)) || (MIN_YELLOW >= (1 << CNT_W))) begin : g_param_check
    $error("traffic_light_monitor: MAX_*/MIN_* must be below 2**CNT_W");
  end

  state_t     r_state;
  logic       r_fault;
  logic [2:0] r_code;
  logic [1:0] r_dir;
  logic       r_force_red;

  logic [2:0] w_lamp [4];
  logic [3:0] w_illegal, w_bad_seq, w_short_green, w_yellow_time, w_starve, w_non_red;
  logic       w_clr;
  logic       w_conflict;
  logic [2:0] w_code;
  logic [1:0] w_dir;

  always_comb begin
    w_lamp[0] = bus.north;
    w_lamp[1] = bus.south;
    w_lamp[2] = bus.east;
    w_lamp[3] = bus.west;
  end

  assign w_clr = (r_state == ST_FAULT) && bus.clear_fault;

  for (genvar d = 0; d < 4; d++) begin : g_dir
    tl_dir_tracker #(
      .CNT_W      (CNT_W),
      .MIN_GREEN  (MIN_GREEN),
      .MIN_YELLOW (MIN_YELLOW),
      .MAX_YELLOW (MAX_YELLOW),
      .MAX_RED    (MAX_RED)
    ) u_trk (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_clr         (w_clr),
      .i_lamp        (w_lamp[d]),
      .o_illegal     (w_illegal[d]),
      .o_bad_seq     (w_bad_seq[d]),
      .o_short_green (w_short_green[d]),
      .o_yellow_time (w_yellow_time[d]),
      .o_starve      (w_starve[d]),
      .o_non_red     (w_non_red[d])
    );
  end

  assign w_conflict = !$onehot0(w_non_red);

  // History-based checks stay quiet in ARM: lamp_p is not trustworthy yet.
  always_comb begin
    w_code = FLT_NONE;
    w_dir  = DIR_N;
    if (|w_illegal) begin
      w_code = FLT_ILLEGAL;
      w_dir  = low_dir(w_illegal);
    end else if (w_conflict) begin
      w_code = FLT_CONFLICT;
    end else if (r_state != ST_ARM) begin
      if (|w_bad_seq) begin
        w_code = FLT_BAD_SEQ;
        w_dir  = low_dir(w_bad_seq);
      end else if (|w_short_green) begin
        w_code = FLT_SHORT_GREEN;
        w_dir  = low_dir(w_short_green);
      end else if (|w_yellow_time) begin
        w_code = FLT_YELLOW_TIME;
        w_dir  = low_dir(w_yellow_time);
      end else if (|w_starve) begin
        w_code = FLT_STARVE;
        w_dir  = low_dir(w_starve);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_ARM;
      r_fault     <= 1'b0;
      r_code      <= FLT_NONE;
      r_dir       <= DIR_N;
      r_force_red <= 1'b0;
    end else begin
      case (r_state)
        ST_ARM, ST_MON: begin
          if (w_code != FLT_NONE) begin
            r_state     <= ST_FAULT;
            r_fault     <= 1'b1;
            r_force_red <= 1'b1;
            r_code      <= w_code;
            r_dir       <= w_dir;
          end else begin
            r_state <= ST_MON;
          end
        end
        ST_FAULT: begin
          if (bus.clear_fault) begin
            r_state     <= ST_ARM;
            r_fault     <= 1'b0;
            r_force_red <= 1'b0;
            r_code      <= FLT_NONE;
            r_dir       <= DIR_N;
          end
        end
        default: r_state <= ST_ARM;
      endcase
    end
  end

  assign bus.fault      = r_fault;
  assign bus.fault_code = r_code;
  assign bus.fault_dir  = r_dir;
  assign bus.force_red  = r_force_red;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ============================================================================
//  Module : tb_traffic_light_monitor
//  Brief  : Scenario bench for traffic_light_monitor with an expectation queue.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_traffic_light_monitor;
  import traffic_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  traffic_light_monitor_if bus();

  traffic_light_monitor #(
    .CNT_W      (8),
    .MIN_GREEN  (4),
    .MIN_YELLOW (2),
    .MAX_YELLOW (6),
    .MAX_RED    (40)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [6:0] exp;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  // {fault, fault_code, fault_dir, force_red}
  function automatic logic [6:0] word(input logic f, input logic [2:0] c,
                                      input logic [1:0] d, input logic r);
    return {f, c, d, r};
  endfunction

  function automatic logic [6:0] obs();
    return {bus.fault, bus.fault_code, bus.fault_dir, bus.force_red};
  endfunction

  task automatic push(input string name, input logic [6:0] exp);
    exp_t x;
    x.name = name;
    x.exp  = exp;
    sb.push_back(x);
  endtask

  task automatic drive(input logic [2:0] n, input logic [2:0] s,
                       input logic [2:0] ea, input logic [2:0] w);
    bus.north = n;
    bus.south = s;
    bus.east  = ea;
    bus.west  = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.clear_fault = 1'b0;
    drive(LAMP_RED, LAMP_RED, LAMP_RED, LAMP_RED);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.clear_fault = 1'b0;
    drive(LAMP_RED, LAMP_RED, LAMP_RED, LAMP_RED);
    #12;
    push("reset_hold", word(1'b0, FLT_NONE, DIR_N, 1'b0));
    e = sb.pop_front(); checks++;
    if (obs() !== e.exp) begin
      failures++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push("reset_release", word(1'b0, FLT_NONE, DIR_N, 1'b0));
    tick();
    e = sb.pop_front(); checks++;
    if (obs() !== e.exp) begin
      failures++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
    end
  endtask

  // All four directions take turns so that no red dwell reaches MAX_RED.
  task automatic test_legal_cycle();
    logic [2:0] l [4];
    apply_reset();
    for (int r = 0; r < 3; r++) begin
      for (int d = 0; d < 4; d++) begin
        for (int k = 0; k < 9; k++) begin
          for (int j = 0; j < 4; j++) l[j] = LAMP_RED;
          l[d] = (k < 6) ? LAMP_GRN : LAMP_YEL;
          drive(l[0], l[1], l[2], l[3]);
          push("legal_cycle", word(1'b0, FLT_NONE, DIR_N, 1'b0));
          tick();
          e = sb.pop_front(); checks++;
          if (obs() !== e.exp) begin
            failures++; $display("FAIL %s r%0d d%0d k%0d: got %b want %b", e.name, r, d, k, obs(), e.exp);
          end
        end
      end
    end
    drive(LAMP_RED, LAMP_RED, LAMP_RED, LAMP_RED);
    for (int k = 0; k < 2; k++) begin
      push("legal_tail", word(1'b0, FLT_NONE, DIR_N, 1'b0));
      tick();
      e = sb.pop_front(); checks++;
      if (obs() !== e.exp) begin
        failures++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
      end
    end
  endtask

  task automatic test_conflict();
    apply_reset();
    drive(LAMP_GRN, LAMP_RED, LAMP_GRN, LAMP_RED);
    push("conflict_edge1", word(1'b0, FLT_NONE, DIR_N, 1'b0));
    push("conflict_edge2", word(1'b1, FLT_CONFLICT, DIR_N, 1'b1));
    for (int k = 0; k < 2; k++) begin
      tick();
      e = sb.pop_front(); checks++;
      if (obs() !== e.exp) begin
        failures++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
      end
    end
  endtask

  task automatic test_bad_seq_clear();
    apply_reset();
    drive(LAMP_RED, LAMP_RED, LAMP_RED, LAMP_YEL);
    push("badseq_edge1", word(1'b0, FLT_NONE, DIR_N, 1'b0));
    push("badseq_edge2", word(1'b1, FLT_BAD_SEQ, DIR_W, 1'b1));
    for (int k = 0; k < 2; k++) begin
      tick();
      e = sb.pop_front(); checks++;
      if (obs() !== e.exp) begin
        failures++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
      end
    end
    // Short yellow while already faulted must not overwrite the code.
    drive(LAMP_RED, LAMP_RED, LAMP_RED, LAMP_RED);
    for (int k = 0; k < 3; k++) begin
      push("badseq_frozen", word(1'b1, FLT_BAD_SEQ, DIR_W, 1'b1));
      tick();
      e = sb.pop_front(); checks++;
      if (obs() !== e.exp) begin
        failures++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
      end
    end
    // R->Y on W alongside the clear lands in ARM, where sequence checks sleep.
    drive(LAMP_RED, LAMP_RED, LAMP_RED, LAMP_YEL);
    bus.clear_fault = 1'b1;
    push("clear_outputs", word(1'b0, FLT_NONE, DIR_N, 1'b0));
    tick();
    bus.clear_fault = 1'b0;
    e = sb.pop_front(); checks++;
    if (obs() !== e.exp) begin
      failures++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
    end
    for (int k = 0; k < 5; k++) begin
      if (k == 2) drive(LAMP_RED, LAMP_RED, LAMP_RED, LAMP_RED);
      push("arm_then_mon", word(1'b0, FLT_NONE, DIR_N, 1'b0));
      tick();
      e = sb.pop_front(); checks++;
      if (obs() !== e.exp) begin
        failures++; $display("FAIL %s k%0d: got %b want %b", e.name, k, obs(), e.exp);
      end
    end
  endtask

  task automatic test_short_green();
    apply_reset();
    drive(LAMP_RED, LAMP_GRN, LAMP_RED, LAMP_RED);
    for (int k = 0; k < 3; k++) begin
      push("sg_green", word(1'b0, FLT_NONE, DIR_N, 1'b0));
      tick();
      e = sb.pop_front(); checks++;
      if (obs() !== e.exp) begin
        failures++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
      end
    end
    drive(LAMP_RED, LAMP_YEL, LAMP_RED, LAMP_RED);
    push("sg_edge1", word(1'b0, FLT_NONE, DIR_N, 1'b0));
    push("sg_edge2", word(1'b1, FLT_SHORT_GREEN, DIR_S, 1'b1));
    for (int k = 0; k < 2; k++) begin
      tick();
      e = sb.pop_front(); checks++;
      if (obs() !== e.exp) begin
        failures++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
      end
    end
    drive(3'b000, LAMP_YEL, LAMP_RED, LAMP_RED);
    for (int k = 0; k < 2; k++) begin
      push("sg_frozen", word(1'b1, FLT_SHORT_GREEN, DIR_S, 1'b1));
      tick();
      e = sb.pop_front(); checks++;
      if (obs() !== e.exp) begin
        failures++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
      end
    end
  endtask

  // E stays red from reset; N, S, W rotate G4/Y2. E's dwell hits 40 at edge 40.
  task automatic test_starve();
    logic [2:0] l [4];
    int         act;
    apply_reset();
    for (int i = 0; i < 43; i++) begin
      for (int j = 0; j < 4; j++) l[j] = LAMP_RED;
      act = (i / 6) % 3;
      act = (act == 0) ? 0 : (act == 1) ? 1 : 3;
      l[act] = ((i % 6) < 4) ? LAMP_GRN : LAMP_YEL;
      drive(l[0], l[1], l[2], l[3]);
      if (i + 1 >= 41) push("starve", word(1'b1, FLT_STARVE, DIR_E, 1'b1));
      else             push("starve_pre", word(1'b0, FLT_NONE, DIR_N, 1'b0));
      tick();
      e = sb.pop_front(); checks++;
      if (obs() !== e.exp) begin
        failures++; $display("FAIL %s edge%0d: got %b want %b", e.name, i + 1, obs(), e.exp);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(LAMP_GRN, LAMP_RED, LAMP_GRN, LAMP_RED);
    push("ar_fault1", word(1'b0, FLT_NONE, DIR_N, 1'b0));
    push("ar_fault2", word(1'b1, FLT_CONFLICT, DIR_N, 1'b1));
    for (int k = 0; k < 2; k++) begin
      tick();
      e = sb.pop_front(); checks++;
      if (obs() !== e.exp) begin
        failures++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    push("ar_async", word(1'b0, FLT_NONE, DIR_N, 1'b0));
    e = sb.pop_front(); checks++;
    if (obs() !== e.exp) begin
      failures++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
    end
    drive(3'b111, LAMP_RED, LAMP_RED, LAMP_RED);
    @(negedge clk);
    rst_n = 1'b1;
    push("ar_ill1", word(1'b0, FLT_NONE, DIR_N, 1'b0));
    push("ar_ill2", word(1'b1, FLT_ILLEGAL, DIR_N, 1'b1));
    for (int k = 0; k < 2; k++) begin
      tick();
      e = sb.pop_front(); checks++;
      if (obs() !== e.exp) begin
        failures++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
      end
    end
    // Clear while the illegal word persists: cleared first, re-detected in ARM.
    bus.clear_fault = 1'b1;
    push("ar_clear", word(1'b0, FLT_NONE, DIR_N, 1'b0));
    tick();
    bus.clear_fault = 1'b0;
    e = sb.pop_front(); checks++;
    if (obs() !== e.exp) begin
      failures++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
    end
    push("ar_redetect", word(1'b1, FLT_ILLEGAL, DIR_N, 1'b1));
    tick();
    e = sb.pop_front(); checks++;
    if (obs() !== e.exp) begin
      failures++; $display("FAIL %s: got %b want %b", e.name, obs(), e.exp);
    end
  endtask

  initial begin
    bus.clear_fault = 1'b0;
    drive(LAMP_RED, LAMP_RED, LAMP_RED, LAMP_RED);
    test_reset();
    test_legal_cycle();
    test_conflict();
    test_bad_seq_clear();
    test_short_green();
    test_starve();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
